// File: rtl/sram_write_buffer.sv
// sram_write_buffer: posted-write FIFO between the cache controller and the SRAM controller.
// Latency: writes complete in the request cycle (ready is combinational); reads return one cycle after sram_ready.
// Backpressure: writes stall while wb_full; reads stall until the buffered writes they depend on have retired.
// Ports: clk/rst; cache side wr_req, rd_req, address, wdata -> ready, rdata;
//        SRAM side sram_write, sram_read, sram_address, sram_wdata <- sram_rdata, sram_ready;
//        status wb_empty, wb_full.
// Optional: define WBUF_CONFLICT_DRAIN_EN to let reads bypass buffered writes to other 8-byte lines.
module sram_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [LINE_W-1:0] rdata,
  output logic              sram_write,
  output logic              sram_read,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [LINE_W-1:0] sram_rdata,
  input  logic              sram_ready,
  output logic              wb_empty,
  output logic              wb_full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RDONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              rd_done_q, rd_done_d;
  logic              push, pop;
  logic              rd_ok_idle;  // read may issue with the FIFO as it stands
  logic              rd_ok_pop;   // read may issue once the head entry pops

  assign wb_empty = (count_q == '0);
  assign wb_full  = (count_q == CNT_W'(DEPTH));

  // Full is judged on the registered count, so a pop in the same cycle
  // does not open a slot until the following cycle. Reads win over writes.
  assign push    = wr_req & ~rd_req & ~wb_full;
  assign pop     = (state_q == S_WR) & sram_ready;
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

`ifdef WBUF_CONFLICT_DRAIN_EN
  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] head_oh;

  // An entry is live when its distance from the read pointer is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    logic [PTR_W-1:0] offs;
    assign offs     = PTR_W'(g) - rd_ptr_q;
    assign match[g] = (CNT_W'(offs) < count_q) &&
                      (addr_mem_q[g][ADDR_W-1:3] == address[ADDR_W-1:3]);
  end

  assign head_oh    = DEPTH'(1) << rd_ptr_q;
  assign rd_ok_idle = ~|match;
  assign rd_ok_pop  = ~|(match & ~head_oh);
`else
  // Drain-all ordering: a read waits until every buffered write has retired.
  assign rd_ok_idle = (count_q == '0);
  assign rd_ok_pop  = (count_q == CNT_W'(1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rdata_q   <= '0;
      rd_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rdata_q   <= rdata_d;
      rd_done_q <= rd_done_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= address;
      data_mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    rd_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Counting the entry pushed this cycle starts its retirement one cycle sooner.
        if (rd_req && rd_ok_idle)          state_d = S_RD;
        else if ((count_q != '0) || push)  state_d = S_WR;
      end
      S_WR: begin
        if (sram_ready) begin
          if (rd_req && rd_ok_pop)         state_d = S_RD;
          else if (count_d != '0)          state_d = S_WR;
          else                             state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (sram_ready) begin
          rdata_d   = sram_rdata;
          rd_done_d = 1'b1;
          state_d   = S_RDONE;
        end
      end
      S_RDONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ready        = push | rd_done_q;
  assign rdata        = rdata_q;
  assign sram_write   = (state_q == S_WR);
  assign sram_read    = (state_q == S_RD);
  assign sram_address = sram_read ? address : addr_mem_q[rd_ptr_q];
  assign sram_wdata   = data_mem_q[rd_ptr_q];

  // The cache controller never presents a read and a write together.
  assert property (@(posedge clk) disable iff (rst) !(wr_req && rd_req));

endmodule

// File: tb/tb_sram_write_buffer.sv
module tb_sram_write_buffer;
  logic        clk = 1'b0;
  logic        rst, wr_req, rd_req, ready, sram_write, sram_read, sram_ready, wb_empty, wb_full;
  logic [31:0] address, wdata, sram_address, sram_wdata;
  logic [63:0] rdata, sram_rdata;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_wq[$];   // expected SRAM writes {addr, data}, in retirement order
  logic [31:0] exp_rq[$];   // expected SRAM read addresses
  logic [63:0] exp_lq[$];   // expected read lines returned to the cache
  int          rd_expect_pending = 0;
  int          wr_seen = 0;
  logic [63:0] mon_w;
  logic [31:0] mon_a;
  logic [63:0] mon_l;

  bit auto_ack = 1'b0;
  int ack_wait = 0;
  int wait_cnt = 0;

  sram_write_buffer dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req), .address(address),
    .wdata(wdata), .ready(ready), .rdata(rdata), .sram_write(sram_write),
    .sram_read(sram_read), .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready), .wb_empty(wb_empty), .wb_full(wb_full)
  );

  always #5 clk = ~clk;

  // SRAM responder: acknowledges a command after ack_wait idle cycles.
  always begin
    @(posedge clk); #1;
    if (auto_ack) begin
      if (!rst && (sram_write || sram_read)) begin
        if (wait_cnt >= ack_wait) begin sram_ready = 1'b1; wait_cnt = 0; end
        else begin sram_ready = 1'b0; wait_cnt++; end
      end else begin
        sram_ready = 1'b0; wait_cnt = 0;
      end
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && (sram_write || sram_read)) begin
      checks++;
      if (sram_write && sram_read) begin
        errors++; $display("FAIL cmd_excl: sram_write=%b sram_read=%b, required not both", sram_write, sram_read);
      end
    end
    if (!rst && sram_ready && sram_write) begin
      checks++; wr_seen++;
      if (exp_wq.size() == 0) begin
        errors++; $display("FAIL sram_wr_extra: got %h/%h, required no write", sram_address, sram_wdata);
      end else begin
        mon_w = exp_wq.pop_front();
        if ({sram_address, sram_wdata} !== mon_w) begin
          errors++; $display("FAIL sram_wr: got %h/%h, required %h/%h", sram_address, sram_wdata, mon_w[63:32], mon_w[31:0]);
        end
      end
    end
    if (!rst && sram_ready && sram_read) begin
      checks++;
      if (exp_rq.size() == 0) begin
        errors++; $display("FAIL sram_rd_extra: got addr %h, required no read", sram_address);
      end else begin
        mon_a = exp_rq.pop_front();
        if (sram_address !== mon_a) begin
          errors++; $display("FAIL sram_rd_addr: got %h, required %h", sram_address, mon_a);
        end
      end
      checks++;
      if (exp_wq.size() != rd_expect_pending) begin
        errors++; $display("FAIL rd_order: pending writes %0d, required %0d", exp_wq.size(), rd_expect_pending);
      end
    end
    if (!rst && rd_req && ready) begin
      checks++;
      if (exp_lq.size() == 0) begin
        errors++; $display("FAIL rd_extra: got rdata %h, required no completion", rdata);
      end else begin
        mon_l = exp_lq.pop_front();
        if (rdata !== mon_l) begin
          errors++; $display("FAIL rdata: got %h, required %h", rdata, mon_l);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int max_cyc);
    bit ok = 1'b0;
    wr_req = 1'b1; address = a; wdata = d;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (ready) begin ok = 1'b1; exp_wq.push_back({a, d}); end
      @(posedge clk); #1;
    end
    wr_req = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL wr_accept: addr %h not accepted, required within %0d cycles", a, max_cyc); end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [63:0] line, input int max_cyc);
    bit ok = 1'b0;
    sram_rdata = line;
    exp_rq.push_back(a);
    exp_lq.push_back(line);
    rd_req = 1'b1; address = a;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    rd_req = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL rd_done: addr %h no ready, required within %0d cycles", a, max_cyc); end
  endtask

  task automatic wait_idle(input int max_cyc);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (wb_empty && !sram_write && !sram_read) ok = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL drain: buffer not idle, required within %0d cycles", max_cyc); end
  endtask

  task automatic test_reset;
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; address = '0; wdata = '0;
    sram_ready = 1'b0; sram_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b0)      begin errors++; $display("FAIL rst_ready: got %b, required 0", ready); end
    checks++; if (sram_write !== 1'b0) begin errors++; $display("FAIL rst_sram_write: got %b, required 0", sram_write); end
    checks++; if (sram_read !== 1'b0)  begin errors++; $display("FAIL rst_sram_read: got %b, required 0", sram_read); end
    checks++; if (wb_empty !== 1'b1)   begin errors++; $display("FAIL rst_wb_empty: got %b, required 1", wb_empty); end
    checks++; if (wb_full !== 1'b0)    begin errors++; $display("FAIL rst_wb_full: got %b, required 0", wb_full); end
    checks++; if (rdata !== 64'h0)     begin errors++; $display("FAIL rst_rdata: got %h, required 0", rdata); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_write;
    auto_ack = 1'b0; sram_ready = 1'b0;
    wr_req = 1'b1; address = 32'h0000_0400; wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL wr_ready_same_cycle: got %b, required 1", ready); end
    else exp_wq.push_back({32'h0000_0400, 32'hDEAD_BEEF});
    @(posedge clk); #1;
    wr_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (sram_write !== 1'b1 || sram_address !== 32'h400 || sram_wdata !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL wr_cmd_hold: got w=%b a=%h d=%h, required 1/00000400/deadbeef", sram_write, sram_address, sram_wdata);
      end
      @(posedge clk); #1;
    end
    sram_ready = 1'b1;
    @(posedge clk); #1;
    sram_ready = 1'b0;
    @(negedge clk);
    checks++; if (sram_write !== 1'b0) begin errors++; $display("FAIL wr_cmd_drop: got %b, required 0", sram_write); end
    checks++; if (wb_empty !== 1'b1)   begin errors++; $display("FAIL wr_empty_after_pop: got %b, required 1", wb_empty); end
    @(posedge clk); #1;
  endtask

  task automatic test_full;
    logic exp_r;
    auto_ack = 1'b0; sram_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_req = 1'b1; address = 32'h100 + 32'(4 * i); wdata = 32'hA000_0000 + 32'(i);
      exp_r = (i < 4);
      @(negedge clk);
      checks++;
      if (ready !== exp_r) begin errors++; $display("FAIL full_accept%0d: got ready=%b, required %b", i, ready, exp_r); end
      if (i < 4 && ready) exp_wq.push_back({address, wdata});
      if (i == 4) begin
        checks++; if (wb_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b, required 1", wb_full); end
      end
      @(posedge clk); #1;
    end
    sram_ready = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL full_pop_same_cycle: got ready=%b, required 0", ready); end
    @(posedge clk); #1;
    sram_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL full_accept_after_pop: got ready=%b, required 1", ready); end
    else exp_wq.push_back({address, wdata});
    checks++; if (wb_full !== 1'b0) begin errors++; $display("FAIL full_after_pop: got %b, required 0", wb_full); end
    @(posedge clk); #1;
    wr_req = 1'b0;
    @(negedge clk);
    checks++; if (wb_full !== 1'b1) begin errors++; $display("FAIL full_refill: got %b, required 1", wb_full); end
    @(posedge clk); #1;
    auto_ack = 1'b1; ack_wait = 0;
    wait_idle(40);
  endtask

  task automatic test_read_order;
    auto_ack = 1'b1; ack_wait = 2;
    rd_expect_pending = 0;
    do_write(32'h1000, 32'h1111_0000, 10);
    do_write(32'h1004, 32'h2222_0000, 10);
    do_write(32'h1000, 32'h3333_0000, 10);
    do_read(32'h1000, 64'h1122_3344_5566_7788, 60);
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rd_ready_one_cycle: got %b, required 0", ready); end
    checks++; if (rdata !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL rdata_hold: got %h, required 1122334455667788", rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap;
    int seen0;
    auto_ack = 1'b1; ack_wait = 0;
    seen0 = wr_seen;
    for (int i = 0; i < 10; i++) do_write(32'h8000 + 32'(16 * i), $urandom, 20);
    wait_idle(50);
    checks++;
    if (wr_seen - seen0 != 10 || exp_wq.size() != 0) begin
      errors++; $display("FAIL wrap_count: got %0d writes (%0d unmatched), required 10 (0)", wr_seen - seen0, exp_wq.size());
    end
  endtask

`ifdef WBUF_CONFLICT_DRAIN_EN
  task automatic test_conflict;
    auto_ack = 1'b1; ack_wait = 1;
    do_write(32'h2000, 32'h0000_2000, 10);
    do_write(32'h3004, 32'h0000_3004, 10);
    rd_expect_pending = 1;
    do_read(32'h5000, 64'hA5A5_A5A5_0000_5000, 40);
    rd_expect_pending = 0;
    do_read(32'h3000, 64'h5A5A_5A5A_0000_3000, 40);
    wait_idle(40);
  endtask
`endif

  task automatic test_reset_mid_read;
    auto_ack = 1'b0; sram_ready = 1'b0;
    sram_rdata = 64'hFFFF_0000_FFFF_0000;
    rd_req = 1'b1; address = 32'h40;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (sram_read !== 1'b1) begin errors++; $display("FAIL mid_rd_issue: got %b, required 1", sram_read); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (sram_read !== 1'b0) begin errors++; $display("FAIL mid_rst_read: got %b, required 0", sram_read); end
    checks++; if (ready !== 1'b0)     begin errors++; $display("FAIL mid_rst_ready: got %b, required 0", ready); end
    checks++; if (wb_empty !== 1'b1)  begin errors++; $display("FAIL mid_rst_empty: got %b, required 1", wb_empty); end
    checks++; if (rdata !== 64'h0)    begin errors++; $display("FAIL mid_rst_rdata: got %h, required 0", rdata); end
    @(posedge clk); #1;
    rd_req = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_full();
    test_read_order();
    test_wrap();
`ifdef WBUF_CONFLICT_DRAIN_EN
    test_conflict();
`endif
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
